multi_vend_ctrl: RTL and testbench

Parametrised multi-item vending controller, successor to the four-drink seller. Accepts coins into a saturating credit register, vends any of `NUM_ITEMS` configurable-price items, returns change, and supports cancel/refund. Per-item stock tracking with sold-out flags is optional. It sits between the coin/keypad front end and the dispenser/change-hopper drivers.

---
 rtl/vend_pkg.sv | 21 ++
 rtl/vend_stock_bank.sv | 40 ++++
 rtl/multi_vend_ctrl.sv | 161 ++++++++++++++++
 tb/tb_multi_vend_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types, default pricing and helpers for the multi-item vending controller.
package vend_pkg;

  typedef enum logic {IDLE, CREDIT} vend_state_e;

  localparam int DEF_NUM_ITEMS = 4;
  localparam int DEF_AMT_W     = 8;
  localparam logic [DEF_NUM_ITEMS*DEF_AMT_W-1:0] DEF_PRICES = {8'd25, 8'd20, 8'd15, 8'd10};

  // Widest price vector supported: 15 items of up to 16 bits each.
  localparam int PRICE_VEC_W = 15 * 16;

  // Price of item idx (1-based) from a zero-extended packed price vector.
  function automatic logic [15:0] price_of(input logic [PRICE_VEC_W-1:0] prices,
                                           input int amtW, input int idx);
    logic [PRICE_VEC_W-1:0] shifted;
    shifted = prices >> ((idx - 1) * amtW);
    return shifted[15:0] & 16'((32'd1 << amtW) - 32'd1);
  endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters: decrement on vend, saturating restock, sold-out flags.
module vend_stock_bank #(
  parameter int NUM_ITEMS  = 4,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5,
  parameter int SEL_W      = 3
) (
  input  logic                 clk_i,
  input  logic                 clear_i,
  input  logic                 dec_i,
  input  logic                 inc_i,
  input  logic [SEL_W-1:0]     idx_i,
  output logic [NUM_ITEMS-1:0] sold_out_o
);

  localparam logic [STOCK_W-1:0] STOCK_MAX  = '1;
  localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);

  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_INIT;
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (idx_i == SEL_W'(i + 1)) begin
          if (dec_i && stock_q[i] != '0)
            stock_q[i] <= stock_q[i] - 1'b1;
          else if (inc_i && stock_q[i] != STOCK_MAX)
            stock_q[i] <= stock_q[i] + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_sold
    assign sold_out_o[g] = (stock_q[g] == '0);
  end

endmodule

// File: rtl/multi_vend_ctrl.sv
// Multi-item vending controller: saturating credit, priced vends, change and refund.
// Optional per-item stock tracking is built when VEND_STOCK_EN is defined.
module multi_vend_ctrl
   import vend_pkg::*;
#(
   parameter int NUM_ITEMS  = DEF_NUM_ITEMS,
   parameter int AMT_W      = DEF_AMT_W,
   parameter logic [NUM_ITEMS*AMT_W-1:0] PRICES = DEF_PRICES,
   parameter int MAX_CREDIT = 255,
   parameter int STOCK_W    = 4,
   parameter int INIT_STOCK = 5
) (
   input  logic                                clk,
   input  logic                                clear,
   input  logic [AMT_W-1:0]                    coin,
   input  logic [$clog2(NUM_ITEMS+1)-1:0]      sel,
   input  logic                                cancel,
`ifdef VEND_STOCK_EN
   input  logic                                restock,
`endif
   output logic [AMT_W-1:0]                    total,
   output logic [AMT_W-1:0]                    exchange,
   output logic [NUM_ITEMS-1:0]                avail,
   output logic [NUM_ITEMS-1:0]                sold_out,
   output logic                                vend_valid,
   output logic [$clog2(NUM_ITEMS+1)-1:0]      vend_item,
   output logic                                coin_rej,
   output logic                                sel_err
);

   localparam int SEL_W = $clog2(NUM_ITEMS + 1);
   localparam logic [PRICE_VEC_W-1:0] PRICE_EXT    = PRICE_VEC_W'(PRICES);
   localparam logic [AMT_W:0]         CREDIT_LIMIT = (AMT_W + 1)'(MAX_CREDIT);

   vend_state_e state_q, state_d;
   logic [AMT_W-1:0] total_q, total_d, exchange_q, exchange_d;
   logic vendValid_q, vendValid_d, coinRej_q, coinRej_d, selErr_q, selErr_d;
   logic [SEL_W-1:0] vendItem_q, vendItem_d;

   logic [AMT_W-1:0] priceArr [NUM_ITEMS];
   logic [NUM_ITEMS-1:0] inStock, soldOut;
   logic [AMT_W-1:0] selPrice;
   logic selInStock, selValid, restockReq;
   logic [AMT_W:0] coinSum;

   // Per-item price lookup and affordability from the registered credit.
   for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_price
      assign priceArr[g] = AMT_W'(price_of(PRICE_EXT, AMT_W, g + 1));
      assign avail[g]    = (total_q >= priceArr[g]) && inStock[g];
   end

`ifdef VEND_STOCK_EN
   logic stockDec, stockInc;
   assign restockReq = restock;
   assign stockDec   = vendValid_d;
   assign stockInc   = restock && selValid && !cancel;

   // Stock bank tracks per-item counts and raises sold-out flags.
   vend_stock_bank #(
      .NUM_ITEMS (NUM_ITEMS),
      .STOCK_W   (STOCK_W),
      .INIT_STOCK(INIT_STOCK),
      .SEL_W     (SEL_W)
   ) u_stock (
      .clk_i     (clk),
      .clear_i   (clear),
      .dec_i     (stockDec),
      .inc_i     (stockInc),
      .idx_i     (sel),
      .sold_out_o(soldOut)
   );
   assign inStock = ~soldOut;
`else
   assign restockReq = 1'b0;
   assign soldOut    = '0;
   assign inStock    = '1;
`endif

   assign selValid = (sel != '0) && (sel <= SEL_W'(NUM_ITEMS));
   assign coinSum  = {1'b0, total_q} + {1'b0, coin};

   // Decode the selected item's price and stock availability.
   always_comb begin
      selPrice   = '0;
      selInStock = 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (sel == SEL_W'(i + 1)) begin
            selPrice   = priceArr[i];
            selInStock = inStock[i];
         end
      end
   end

   // Priority: cancel, then restock, then selection, then coin; clear is in the register.
   always_comb begin
      state_d     = state_q;
      total_d     = total_q;
      exchange_d  = exchange_q;
      vendValid_d = 1'b0;
      vendItem_d  = '0;
      coinRej_d   = 1'b0;
      selErr_d    = 1'b0;
      if (cancel) begin
         exchange_d = total_q;
         total_d    = '0;
         state_d    = IDLE;
         coinRej_d  = (coin != '0);
      end else if (restockReq && selValid) begin
         coinRej_d = (coin != '0);
      end else if (sel != '0) begin
         coinRej_d = (coin != '0);
         if (selValid && total_q >= selPrice && selInStock) begin
            vendValid_d = 1'b1;
            vendItem_d  = sel;
            exchange_d  = total_q - selPrice;
            total_d     = '0;
            state_d     = IDLE;
         end else begin
            selErr_d = 1'b1;
         end
      end else if (coin != '0) begin
         if (coinSum <= CREDIT_LIMIT) begin
            total_d    = coinSum[AMT_W-1:0];
            exchange_d = '0;
            state_d    = CREDIT;
         end else begin
            coinRej_d = 1'b1;
         end
      end
   end

   // State and output registers with synchronous clear.
   always_ff @(posedge clk) begin
      if (clear) begin
         state_q     <= IDLE;
         total_q     <= '0;
         exchange_q  <= '0;
         vendValid_q <= 1'b0;
         vendItem_q  <= '0;
         coinRej_q   <= 1'b0;
         selErr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         total_q     <= total_d;
         exchange_q  <= exchange_d;
         vendValid_q <= vendValid_d;
         vendItem_q  <= vendItem_d;
         coinRej_q   <= coinRej_d;
         selErr_q    <= selErr_d;
      end
   end

   assign total      = total_q;
   assign exchange   = exchange_q;
   assign sold_out   = soldOut;
   assign vend_valid = vendValid_q;
   assign vend_item  = vendItem_q;
   assign coin_rej   = coinRej_q;
   assign sel_err    = selErr_q;

endmodule

// File: tb/tb_multi_vend_ctrl.sv
// Testbench for multi_vend_ctrl: fixed vector table, stock/hold sequences, and
// randomized traffic against a reference model (stock checks under VEND_STOCK_EN).
module tb_multi_vend_ctrl;

   localparam int NI = 4;
   localparam int AW = 8;
   localparam int SW = 3;
`ifdef VEND_STOCK_EN
   localparam bit HAS_STOCK = 1'b1;
   localparam int INIT_STK  = 5;
`else
   localparam bit HAS_STOCK = 1'b0;
   localparam int INIT_STK  = 5;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic clear, cancel;
   logic [AW-1:0] coin;
   logic [SW-1:0] sel;
`ifdef VEND_STOCK_EN
   logic restock;
`endif
   logic [AW-1:0] total, exchange;
   logic [NI-1:0] avail, soldOut;
   logic vendValid, coinRej, selErr;
   logic [SW-1:0] vendItem;

   multi_vend_ctrl #(.INIT_STOCK(INIT_STK)) dut (
      .clk       (clk),
      .clear     (clear),
      .coin      (coin),
      .sel       (sel),
      .cancel    (cancel),
`ifdef VEND_STOCK_EN
      .restock   (restock),
`endif
      .total     (total),
      .exchange  (exchange),
      .avail     (avail),
      .sold_out  (soldOut),
      .vend_valid(vendValid),
      .vend_item (vendItem),
      .coin_rej  (coinRej),
      .sel_err   (selErr)
   );

   int compared = 0;
   int mismatched = 0;

   // Reference model: credit and change as plain integers, stock as a count per item.
   int prices [NI] = '{10, 15, 20, 25};
   int mTotal = 0, mExch = 0, mItem = 0;
   int mStock [NI];
   bit mVV = 0, mRej = 0, mErr = 0;

   typedef struct {
      logic clr; logic cnl; logic [7:0] coin; logic [2:0] sel;
      logic [7:0] eTotal; logic [7:0] eExch; logic eVV; logic [2:0] eItem;
      logic eRej; logic eErr; logic [3:0] eAvail;
   } vec_t;
   vec_t vecs[$];

   task automatic checkVal(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic modelStep(input bit clr, input bit cnl, input bit rst, input int cn, input int sl);
      mVV = 0; mItem = 0; mRej = 0; mErr = 0;
      if (clr) begin
         mTotal = 0; mExch = 0;
         for (int i = 0; i < NI; i++) mStock[i] = HAS_STOCK ? INIT_STK : 1;
      end else if (cnl) begin
         mExch = mTotal; mTotal = 0; mRej = (cn != 0);
      end else if (HAS_STOCK && rst && sl >= 1 && sl <= NI) begin
         if (mStock[sl-1] < 15) mStock[sl-1]++;
         mRej = (cn != 0);
      end else if (sl != 0) begin
         mRej = (cn != 0);
         if (sl <= NI && mTotal >= prices[sl-1] && mStock[sl-1] > 0) begin
            mVV = 1; mItem = sl; mExch = mTotal - prices[sl-1]; mTotal = 0;
            if (HAS_STOCK) mStock[sl-1]--;
         end else mErr = 1;
      end else if (cn != 0) begin
         if (mTotal + cn <= 255) begin mTotal += cn; mExch = 0; end
         else mRej = 1;
      end
   endtask

   function automatic logic [3:0] modelAvail();
      logic [3:0] a;
      for (int i = 0; i < NI; i++) a[i] = (mTotal >= prices[i]) && (mStock[i] > 0);
      return a;
   endfunction

   function automatic logic [3:0] modelSold();
      logic [3:0] s;
      for (int i = 0; i < NI; i++) s[i] = HAS_STOCK && (mStock[i] == 0);
      return s;
   endfunction

   task automatic applyStimulus(input bit clr, input bit cnl, input bit rst, input int cn, input int sl);
      clear = clr; cancel = cnl; coin = AW'(cn); sel = SW'(sl);
`ifdef VEND_STOCK_EN
      restock = rst;
`endif
      modelStep(clr, cnl, rst, cn, sl);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string nm);
      checkVal({nm, "/total"}, 32'(total), 32'(mTotal));
      checkVal({nm, "/exchange"}, 32'(exchange), 32'(mExch));
      checkVal({nm, "/vend_valid"}, 32'(vendValid), 32'(mVV));
      checkVal({nm, "/vend_item"}, 32'(vendItem), 32'(mItem));
      checkVal({nm, "/coin_rej"}, 32'(coinRej), 32'(mRej));
      checkVal({nm, "/sel_err"}, 32'(selErr), 32'(mErr));
      checkVal({nm, "/avail"}, 32'(avail), 32'(modelAvail()));
      checkVal({nm, "/sold_out"}, 32'(soldOut), 32'(modelSold()));
   endtask

   task automatic step(input string nm, input bit clr, input bit cnl, input bit rst, input int cn, input int sl);
      applyStimulus(clr, cnl, rst, cn, sl);
      checkOutput(nm);
   endtask

   task automatic addVec(input logic clr, input logic cnl, input logic [7:0] cn, input logic [2:0] sl,
                         input logic [7:0] t, input logic [7:0] ex, input logic vv, input logic [2:0] it,
                         input logic rj, input logic er, input logic [3:0] av);
      vec_t v;
      v.clr = clr; v.cnl = cnl; v.coin = cn; v.sel = sl;
      v.eTotal = t; v.eExch = ex; v.eVV = vv; v.eItem = it;
      v.eRej = rj; v.eErr = er; v.eAvail = av;
      vecs.push_back(v);
   endtask

   // Main sequence: directed vectors, hold test, stock test, then random traffic.
   initial begin
      int cn, sl;
      bit clr, cnl, rst;
      int coinSet [7] = '{0, 1, 5, 10, 25, 100, 200};
      string nm;

      clear = 1'b1; cancel = 1'b0; coin = '0; sel = '0;
`ifdef VEND_STOCK_EN
      restock = 1'b0;
`endif

      //     clr cnl coin sel  total exch vv item rej err avail
      addVec(1, 0,   0, 0,     0,   0, 0, 0, 0, 0, 4'b0000);
      addVec(0, 0,  10, 0,    10,   0, 0, 0, 0, 0, 4'b0001);
      addVec(0, 0,   5, 0,    15,   0, 0, 0, 0, 0, 4'b0011);
      addVec(0, 0,   1, 0,    16,   0, 0, 0, 0, 0, 4'b0011);
      addVec(0, 0,  10, 0,    26,   0, 0, 0, 0, 0, 4'b1111);
      addVec(0, 0,   0, 3,     0,   6, 1, 3, 0, 0, 4'b0000);
      addVec(0, 0,  16, 0,    16,   0, 0, 0, 0, 0, 4'b0011);
      addVec(0, 0,   0, 4,    16,   0, 0, 0, 0, 1, 4'b0011);
      addVec(0, 1,   0, 0,     0,  16, 0, 0, 0, 0, 4'b0000);
      addVec(0, 1,   0, 0,     0,   0, 0, 0, 0, 0, 4'b0000);
      addVec(0, 0, 250, 0,   250,   0, 0, 0, 0, 0, 4'b1111);
      addVec(0, 0,  10, 0,   250,   0, 0, 0, 1, 0, 4'b1111);
      addVec(0, 1,   7, 0,     0, 250, 0, 0, 1, 0, 4'b0000);
      addVec(0, 0,  20, 0,    20,   0, 0, 0, 0, 0, 4'b0111);
      addVec(0, 0,   5, 1,     0,  10, 1, 1, 1, 0, 4'b0000);
      addVec(0, 0,   0, 5,     0,  10, 0, 0, 0, 1, 4'b0000);
      addVec(0, 0,  15, 0,    15,   0, 0, 0, 0, 0, 4'b0011);
      addVec(1, 0,  10, 0,     0,   0, 0, 0, 0, 0, 4'b0000);
      addVec(0, 0, 255, 0,   255,   0, 0, 0, 0, 0, 4'b1111);
      addVec(0, 0,   1, 0,   255,   0, 0, 0, 1, 0, 4'b1111);
      addVec(0, 0,   0, 7,   255,   0, 0, 0, 0, 1, 4'b1111);
      addVec(1, 0,   0, 0,     0,   0, 0, 0, 0, 0, 4'b0000);

      for (int k = 0; k < vecs.size(); k++) begin
         applyStimulus(vecs[k].clr, vecs[k].cnl, 1'b0, int'(vecs[k].coin), int'(vecs[k].sel));
         nm = $sformatf("vec%0d", k);
         checkVal({nm, "/total"}, 32'(total), 32'(vecs[k].eTotal));
         checkVal({nm, "/exchange"}, 32'(exchange), 32'(vecs[k].eExch));
         checkVal({nm, "/vend_valid"}, 32'(vendValid), 32'(vecs[k].eVV));
         checkVal({nm, "/vend_item"}, 32'(vendItem), 32'(vecs[k].eItem));
         checkVal({nm, "/coin_rej"}, 32'(coinRej), 32'(vecs[k].eRej));
         checkVal({nm, "/sel_err"}, 32'(selErr), 32'(vecs[k].eErr));
         checkVal({nm, "/avail"}, 32'(avail), 32'(vecs[k].eAvail));
         checkVal({nm, "/sold_out"}, 32'(soldOut), 32'd0);
      end

      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0, 5, 0);
      checkVal("hold/total", 32'(total), 32'd15);
      step("hold_cancel", 1'b0, 1'b1, 1'b0, 0, 0);
      checkVal("hold_cancel/exchange", 32'(exchange), 32'd15);

`ifdef VEND_STOCK_EN
      step("stk_clear", 1'b1, 1'b0, 1'b0, 0, 0);
      for (int k = 0; k < INIT_STK; k++) begin
         step("stk_coin", 1'b0, 1'b0, 1'b0, 10, 0);
         step("stk_vend", 1'b0, 1'b0, 1'b0, 0, 1);
         checkVal("stk_vend/vend_valid", 32'(vendValid), 32'd1);
      end
      step("stk_coin", 1'b0, 1'b0, 1'b0, 10, 0);
      step("stk_empty", 1'b0, 1'b0, 1'b0, 0, 1);
      checkVal("stk_empty/sel_err", 32'(selErr), 32'd1);
      checkVal("stk_empty/sold_out0", 32'(soldOut[0]), 32'd1);
      checkVal("stk_empty/total", 32'(total), 32'd10);
      step("stk_restock", 1'b0, 1'b0, 1'b1, 5, 1);
      checkVal("stk_restock/sold_out0", 32'(soldOut[0]), 32'd0);
      checkVal("stk_restock/coin_rej", 32'(coinRej), 32'd1);
      checkVal("stk_restock/vend_valid", 32'(vendValid), 32'd0);
      step("stk_clear2", 1'b1, 1'b0, 1'b0, 0, 0);
`endif

      for (int k = 0; k < 600; k++) begin
         clr = ($urandom_range(0, 99) < 2);
         cnl = ($urandom_range(0, 99) < 6);
         rst = HAS_STOCK && ($urandom_range(0, 99) < 10);
         sl  = ($urandom_range(0, 99) < 30) ? int'($urandom_range(1, 7)) : 0;
         cn  = coinSet[$urandom_range(0, 6)];
         step($sformatf("rand%0d", k), clr, cnl, rst, cn, sl);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
